// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - Moore control FSM for the multicycle MIPS datapath
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       pcEn,
    output logic       iord,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [2:0] aluControl,
    output logic [1:0] pcSrc,
    output logic       signExtend,
    output logic       illegalOp,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t cur_state, nxt_state;

    assign state = cur_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= S_FETCH;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state  = S_FETCH;
        pcEn       = 1'b0;
        iord       = 1'b0;
        memWrite   = 1'b0;
        irWrite    = 1'b0;
        regDst     = 1'b0;
        memToReg   = 1'b0;
        regWrite   = 1'b0;
        aluSrcA    = 1'b0;
        aluSrcB    = 2'b00;
        aluControl = 3'b000;
        pcSrc      = 2'b00;
        illegalOp  = 1'b0;
        // Decoded in every state so DECODE already sees the new opcode for branch targets.
        signExtend = (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_BEQ) ||
                     (opcode == OP_BNE) || (opcode == OP_ADDI);

        case (cur_state)
            S_FETCH: begin
                nxt_state  = S_DECODE;
                irWrite    = 1'b1;
                aluSrcB    = 2'b01;
                aluControl = ALU_ADD;
                pcEn       = 1'b1;
            end
            S_DECODE: begin
                aluSrcB    = 2'b11;
                aluControl = ALU_ADD;
                case (opcode)
                    OP_LW, OP_SW:            nxt_state = S_MEMADR;
                    OP_RTYPE:                nxt_state = S_RTYPEEX;
                    OP_BEQ, OP_BNE:          nxt_state = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI: nxt_state = S_IMMEX;
                    OP_J:                    nxt_state = S_JUMP;
                    default: begin
                        nxt_state = S_FETCH;
                        illegalOp = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                nxt_state  = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b10;
                aluControl = ALU_ADD;
            end
            S_MEMRD: begin
                nxt_state = S_MEMWB;
                iord      = 1'b1;
            end
            S_MEMWB: begin
                regWrite = 1'b1;
                memToReg = 1'b1;
            end
            S_MEMWR: begin
                iord     = 1'b1;
                memWrite = 1'b1;
            end
            S_RTYPEEX: begin
                nxt_state = S_ALUWB;
                aluSrcA   = 1'b1;
                aluSrcB   = 2'b00;
                // Unknown funct still completes as an add so the pipeline of states stays uniform.
                case (funct)
                    6'h20:   aluControl = ALU_ADD;
                    6'h22:   aluControl = ALU_SUB;
                    6'h24:   aluControl = ALU_AND;
                    6'h25:   aluControl = ALU_OR;
                    6'h2A:   aluControl = ALU_SLT;
                    default: begin
                        aluControl = ALU_ADD;
                        illegalOp  = 1'b1;
                    end
                endcase
            end
            S_ALUWB: begin
                regWrite = 1'b1;
                regDst   = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA    = 1'b1;
                aluSrcB    = 2'b00;
                aluControl = ALU_SUB;
                pcSrc      = 2'b01;
                pcEn       = ((opcode == OP_BEQ) && zero) || ((opcode == OP_BNE) && !zero);
            end
            S_IMMEX: begin
                nxt_state = S_IMMWB;
                aluSrcA   = 1'b1;
                aluSrcB   = 2'b10;
                case (opcode)
                    OP_ANDI: aluControl = ALU_AND;
                    OP_ORI:  aluControl = ALU_OR;
                    default: aluControl = ALU_ADD;
                endcase
            end
            S_IMMWB: begin
                regWrite = 1'b1;
            end
            S_JUMP: begin
                pcSrc = 2'b10;
                pcEn  = 1'b1;
            end
            default: nxt_state = S_FETCH;
        endcase

        // Reset silences every strobe in the same cycle it asserts.
        if (reset) begin
            pcEn       = 1'b0;
            iord       = 1'b0;
            memWrite   = 1'b0;
            irWrite    = 1'b0;
            regDst     = 1'b0;
            memToReg   = 1'b0;
            regWrite   = 1'b0;
            aluSrcA    = 1'b0;
            aluSrcB    = 2'b00;
            aluControl = 3'b000;
            pcSrc      = 2'b00;
            signExtend = 1'b0;
            illegalOp  = 1'b0;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       pcEn, iord, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA;
    logic [1:0] aluSrcB, pcSrc;
    logic [2:0] aluControl;
    logic       signExtend, illegalOp;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    logic [3:0]  exp_st[$];
    logic [16:0] exp_out[$];
    logic [16:0] obs;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .pcEn(pcEn), .iord(iord), .memWrite(memWrite), .irWrite(irWrite),
        .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluControl(aluControl),
        .pcSrc(pcSrc), .signExtend(signExtend), .illegalOp(illegalOp), .state(state)
    );

    always #5 clk = ~clk;

    assign obs = {pcEn, iord, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA,
                  aluSrcB, aluControl, pcSrc, signExtend, illegalOp};

    function automatic logic [16:0] mk(input logic pcen, input logic io, input logic mw,
                                       input logic irw, input logic rd, input logic m2r,
                                       input logic rw, input logic sa, input logic [1:0] sb,
                                       input logic [2:0] ac, input logic [1:0] ps,
                                       input logic se, input logic ill);
        return {pcen, io, mw, irw, rd, m2r, rw, sa, sb, ac, ps, se, ill};
    endfunction

    // Per-instruction cycle script: which phases run and what each phase must drive.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z);
        logic se, legal, fn_ok;
        logic [2:0] rac;
        se    = (op == 6'h23 || op == 6'h2B || op == 6'h04 || op == 6'h05 || op == 6'h08);
        legal = (op == 6'h23 || op == 6'h2B || op == 6'h00 || op == 6'h04 || op == 6'h05 ||
                 op == 6'h08 || op == 6'h0C || op == 6'h0D || op == 6'h02);
        exp_st.delete();
        exp_out.delete();
        exp_st.push_back(4'd0); exp_out.push_back(mk(1,0,0,1,0,0,0,0,2'b01,3'b010,2'b00,se,0));
        exp_st.push_back(4'd1); exp_out.push_back(mk(0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,se,!legal));
        if (op == 6'h23 || op == 6'h2B) begin
            exp_st.push_back(4'd2); exp_out.push_back(mk(0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,se,0));
            if (op == 6'h23) begin
                exp_st.push_back(4'd3); exp_out.push_back(mk(0,1,0,0,0,0,0,0,2'b00,3'b000,2'b00,se,0));
                exp_st.push_back(4'd4); exp_out.push_back(mk(0,0,0,0,0,1,1,0,2'b00,3'b000,2'b00,se,0));
            end else begin
                exp_st.push_back(4'd5); exp_out.push_back(mk(0,1,1,0,0,0,0,0,2'b00,3'b000,2'b00,se,0));
            end
        end else if (op == 6'h00) begin
            fn_ok = 1'b1;
            case (fn)
                6'h20: rac = 3'b010;
                6'h22: rac = 3'b110;
                6'h24: rac = 3'b000;
                6'h25: rac = 3'b001;
                6'h2A: rac = 3'b111;
                default: begin rac = 3'b010; fn_ok = 1'b0; end
            endcase
            exp_st.push_back(4'd6); exp_out.push_back(mk(0,0,0,0,0,0,0,1,2'b00,rac,2'b00,se,!fn_ok));
            exp_st.push_back(4'd7); exp_out.push_back(mk(0,0,0,0,1,0,1,0,2'b00,3'b000,2'b00,se,0));
        end else if (op == 6'h04 || op == 6'h05) begin
            exp_st.push_back(4'd8);
            exp_out.push_back(mk((op == 6'h04) ? z : !z,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,se,0));
        end else if (op == 6'h08 || op == 6'h0C || op == 6'h0D) begin
            rac = (op == 6'h0C) ? 3'b000 : (op == 6'h0D) ? 3'b001 : 3'b010;
            exp_st.push_back(4'd9);  exp_out.push_back(mk(0,0,0,0,0,0,0,1,2'b10,rac,2'b00,se,0));
            exp_st.push_back(4'd10); exp_out.push_back(mk(0,0,0,0,0,0,1,0,2'b00,3'b000,2'b00,se,0));
        end else if (op == 6'h02) begin
            exp_st.push_back(4'd11); exp_out.push_back(mk(1,0,0,0,0,0,0,0,2'b00,3'b000,2'b10,se,0));
        end
    endtask

    // Entered just after a rising edge with the DUT in FETCH; leaves it the same way.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int exp_cycles);
        build(op, fn, z);
        for (int i = 0; i < exp_st.size(); i++) begin
            opcode = op;
            funct  = fn;
            zero   = z;
            #2;
            checks++;
            if (state !== exp_st[i]) begin
                errors++;
                $display("FAIL state op=%h fn=%h step=%0d actual=%0d required=%0d",
                         op, fn, i, state, exp_st[i]);
            end
            checks++;
            if (obs !== exp_out[i]) begin
                errors++;
                $display("FAIL outputs op=%h fn=%h step=%0d actual=%b required=%b",
                         op, fn, i, obs, exp_out[i]);
            end
            @(posedge clk);
            #1;
        end
        #2;
        checks++;
        if (state !== 4'd0 || exp_st.size() != exp_cycles) begin
            errors++;
            $display("FAIL length op=%h actual_state=%0d model_cycles=%0d required_cycles=%0d",
                     op, state, exp_st.size(), exp_cycles);
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        opcode = 6'h23;
        funct  = 6'h20;
        zero   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            checks++;
            if (state !== 4'd0 || obs !== 17'd0) begin
                errors++;
                $display("FAIL reset_hold actual_state=%0d actual_out=%b required=0", state, obs);
            end
            @(posedge clk);
            #1;
            opcode = 6'($urandom);
        end
        reset = 1'b0;
    endtask

    task automatic test_lw();
        run_instr(6'h23, 6'($urandom), 1'($urandom), 5);
    endtask

    task automatic test_sw();
        run_instr(6'h2B, 6'($urandom), 1'($urandom), 4);
    endtask

    task automatic test_imm();
        run_instr(6'h0C, 6'($urandom), 1'($urandom), 4);
        run_instr(6'h08, 6'($urandom), 1'($urandom), 4);
        run_instr(6'h0D, 6'($urandom), 1'($urandom), 4);
    endtask

    task automatic test_branch();
        run_instr(6'h04, 6'h00, 1'b1, 3);
        run_instr(6'h05, 6'h00, 1'b1, 3);
        run_instr(6'h04, 6'h00, 1'b0, 3);
        run_instr(6'h05, 6'h00, 1'b0, 3);
    endtask

    task automatic test_rtype();
        run_instr(6'h00, 6'h2A, 1'b0, 4);
        run_instr(6'h00, 6'h3F, 1'b0, 4);
        run_instr(6'h00, 6'h22, 1'b1, 4);
    endtask

    task automatic test_illegal_op();
        run_instr(6'h3F, 6'h20, 1'b0, 2);
    endtask

    task automatic test_jump();
        run_instr(6'h02, 6'h00, 1'b0, 3);
    endtask

    task automatic test_reset_midflight();
        int budget;
        opcode = 6'h23;
        funct  = 6'h20;
        zero   = 1'b0;
        budget = 0;
        #1;
        while (state !== 4'd3 && budget < 10) begin
            @(posedge clk);
            #1;
            budget++;
        end
        checks++;
        if (state !== 4'd3) begin
            errors++;
            $display("FAIL reach_memrd actual=%0d required=3", state);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || obs !== 17'd0) begin
            errors++;
            $display("FAIL reset_async actual_state=%0d actual_out=%b required=0", state, obs);
        end
        @(posedge clk);
        #1;
        checks++;
        if (state !== 4'd0 || obs !== 17'd0) begin
            errors++;
            $display("FAIL reset_held actual_state=%0d actual_out=%b required=0", state, obs);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (pcEn !== 1'b1 || irWrite !== 1'b1 || state !== 4'd0) begin
            errors++;
            $display("FAIL reset_release actual pcEn=%b irWrite=%b state=%0d required 1 1 0",
                     pcEn, irWrite, state);
        end
        run_instr(6'h23, 6'h20, 1'b0, 5);
    endtask

    task automatic test_back_to_back();
        logic [5:0] legal_ops[9];
        logic [5:0] functs[5];
        logic [5:0] op, fn;
        int cyc;
        legal_ops = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h02};
        functs    = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        for (int n = 0; n < 80; n++) begin
            op = ($urandom_range(0, 9) < 8) ? legal_ops[$urandom_range(0, 8)]
                                            : 6'($urandom_range(0, 63));
            fn = ($urandom_range(0, 4) < 4) ? functs[$urandom_range(0, 4)]
                                            : 6'($urandom_range(0, 63));
            case (op)
                6'h23:                      cyc = 5;
                6'h2B, 6'h00:               cyc = 4;
                6'h08, 6'h0C, 6'h0D:        cyc = 4;
                6'h04, 6'h05, 6'h02:        cyc = 3;
                default:                    cyc = 2;
            endcase
            run_instr(op, fn, 1'($urandom), cyc);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_imm();
        test_branch();
        test_rtype();
        test_illegal_op();
        test_jump();
        test_reset_midflight();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Moore-style control FSM for the multicycle MIPS datapath. Decodes the opcode and funct fields held in the instruction register and sequences PC, memory, register file, ALU and sign extender over 3–5 cycles per instruction. It is the sole driver of the sign extender's `signExtend` mode input.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates occur on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `opcode` in 6: instr[31:26], from the instruction register (stable from the DECODE state onward).
- `funct` in 6: instr[5:0].
- `zero` in 1: ALU zero flag.
- `pcEn` out 1: PC register write enable.
- `iord` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `memWrite` out 1: data memory write.
- `irWrite` out 1: instruction register load.
- `regDst` out 1: register write address select. 0 = rt, 1 = rd.
- `memToReg` out 1: register write data select. 0 = ALUOut, 1 = memory data.
- `regWrite` out 1: register file write.
- `aluSrcA` out 1: ALU A select. 0 = PC, 1 = register A.
- `aluSrcB` out 2: ALU B select. 00 = B, 01 = 4, 10 = extended immediate, 11 = extended immediate << 2.
- `aluControl` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `pcSrc` out 2: PC source. 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `signExtend` out 1: sign extender mode. 1 = sign-extend, 0 = zero-extend.
- `illegalOp` out 1: one-cycle pulse on an unsupported opcode or funct.
- `state` out 4: current state code, for debug.

## Operation
- States and codes:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPEEX=6, ALUWB=7, BRANCH=8, IMMEX=9, IMMWB=10, JUMP=11.
  - Codes 12–15 are unreachable; if entered, go to FETCH.
- Transitions:
  - FETCH→DECODE.
  - DECODE:
    - lw(0x23) / sw(0x2B) → MEMADR.
    - R-type(0x00) → RTYPEEX.
    - beq(0x04) / bne(0x05) → BRANCH.
    - addi(0x08) / andi(0x0C) / ori(0x0D) → IMMEX.
    - j(0x02) → JUMP.
    - Any other opcode → FETCH, with `illegalOp`=1 in DECODE.
  - MEMADR→MEMRD for lw, MEMWR for sw.
  - MEMRD→MEMWB.
  - RTYPEEX→ALUWB.
  - IMMEX→IMMWB.
  - MEMWB, MEMWR, ALUWB, IMMWB, BRANCH, JUMP → FETCH.
- Outputs are 0 unless listed for the state:
  - FETCH: `irWrite`=1, `aluSrcB`=01, `aluControl`=010, `pcSrc`=00, `pcEn`=1.
  - DECODE: `aluSrcB`=11, `aluControl`=010 (branch target into ALUOut).
  - MEMADR: `aluSrcA`=1, `aluSrcB`=10, `aluControl`=010.
  - MEMRD: `iord`=1.
  - MEMWB: `regWrite`=1, `memToReg`=1, `regDst`=0.
  - MEMWR: `iord`=1, `memWrite`=1.
  - RTYPEEX: `aluSrcA`=1, `aluSrcB`=00, `aluControl` from funct:
    - add 0x20 → 010; sub 0x22 → 110; and 0x24 → 000; or 0x25 → 001; slt 0x2A → 111.
    - Any other funct → 010, with `illegalOp`=1 in RTYPEEX; the sequence still completes.
  - ALUWB: `regWrite`=1, `regDst`=1.
  - BRANCH: `aluSrcA`=1, `aluSrcB`=00, `aluControl`=110, `pcSrc`=01.
    - `pcEn` = `zero` for beq, `!zero` for bne.
  - IMMEX: `aluSrcA`=1, `aluSrcB`=10.
    - `aluControl`: addi → 010, andi → 000, ori → 001.
  - IMMWB: `regWrite`=1, `regDst`=0, `memToReg`=0.
  - JUMP: `pcSrc`=10, `pcEn`=1.
- `signExtend`:
  - Decoded from `opcode` in every state.
  - 1 for lw, sw, beq, bne, addi.
  - 0 for andi, ori, and all other opcodes.
  - In DECODE it must reflect the new opcode, because branch target math uses it.

## Timing
- Outputs are combinational from `state`, `opcode`, `funct` and `zero`. No output registers.
- Next state is registered on the `clk` rising edge.
- Cycles per instruction: lw 5; sw 4; R-type 4; addi/andi/ori 4; beq/bne 3; j 3; illegal opcode 2.
- While `reset`=1:
  - `state`=FETCH immediately (asynchronous).
  - All outputs are forced to 0, including `pcEn`, `irWrite` and `illegalOp`.
- The first rising edge after `reset` deasserts completes a FETCH.
- Reset asserted mid-instruction aborts it. No write strobe may assert after reset asserts.
- `zero` is sampled only in BRANCH; it is a don't-care elsewhere.

## Test plan
- Reset:
  - Assert `reset` mid-MEMRD → `state`=0 and all outputs 0 in the same cycle.
  - Deassert → the next cycle shows FETCH outputs (`pcEn`=1, `irWrite`=1).
- lw (opcode 0x23):
  - Expected state sequence 0,1,2,3,4,0.
  - `signExtend`=1 throughout.
  - MEMWB drives `regWrite`=1, `memToReg`=1.
- andi (0x0C) then addi (0x08):
  - `signExtend`=0 then 1.
  - IMMEX `aluControl`=000 then 010.
  - 4 cycles each.
- beq (0x04) with `zero`=1 → BRANCH `pcEn`=1.
- bne (0x05) with `zero`=1 → `pcEn`=0.
- Both branches take 3 cycles and use `pcSrc`=01.
- R-type slt (funct 0x2A) → RTYPEEX `aluControl`=111, ALUWB `regDst`=1.
- Funct 0x3F → `illegalOp` pulses for exactly 1 cycle in RTYPEEX.
- Opcode 0x3F → `illegalOp`=1 in DECODE only, then return to FETCH after 2 cycles.
- j (0x02) → JUMP `pcSrc`=10, `pcEn`=1.
